// File: rtl/axi_read_burst_splitter_pkg.sv
// Shared constants, FSM encoding and helpers for the AXI read burst splitter.
package axi_read_burst_splitter_pkg;

   localparam int unsigned AXI_MAX_BEATS = 256;
   localparam int unsigned AXI_BOUNDARY  = 4096;
   localparam int          AXI_ADDR_W    = 32;
   localparam int          AXI_LEN_W     = 8;
   // Remaining-beat count is one bit wider than the address so ceil(0xFFFFFFFF/BB) stays exact.
   localparam int          BEATS_W       = AXI_ADDR_W + 1;
   localparam int          N_W           = AXI_LEN_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CALC  = 2'd1,
      ST_ISSUE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(value)) r++;
      return r;
   endfunction

endpackage

// File: rtl/axi_burst_calc.sv
// Burst size for the next request: min of remaining beats, MAX_BEATS and beats left in the page.
module axi_burst_calc
   import axi_read_burst_splitter_pkg::*;
#(
   parameter int unsigned BB        = 8,
   parameter int unsigned MAX_BEATS = AXI_MAX_BEATS,
   parameter int unsigned BOUNDARY  = AXI_BOUNDARY
) (
   input  logic [AXI_ADDR_W-1:0] addr,
   input  logic [BEATS_W-1:0]    beats_rem,
   output logic [N_W-1:0]        n
);

   localparam int unsigned BB_LOG = clog2(BB);

   logic [BEATS_W-1:0] page_off;
   logic [BEATS_W-1:0] page_beats;
   logic [BEATS_W-1:0] max_beats;
   logic [BEATS_W-1:0] lim;

   always_comb begin
      page_off   = {1'b0, addr} & BEATS_W'(BOUNDARY - 1);
      page_beats = (BEATS_W'(BOUNDARY) - page_off) >> BB_LOG;
      max_beats  = BEATS_W'(MAX_BEATS);
      lim        = (beats_rem < max_beats) ? beats_rem : max_beats;
      if (page_beats < lim) lim = page_beats;
      // lim never exceeds MAX_BEATS, so it fits in N_W bits
      n = N_W'(lim);
   end

endmodule

// File: rtl/axi_read_burst_splitter.sv
// Splits (address, byte-count) read commands into AXI4 INCR bursts that respect
// MAX_BEATS and the BOUNDARY page, one command in flight at a time.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | ready for a command; latch aligned address and beat count
// ST_CALC  | size the next burst and load the burst request registers
// ST_ISSUE | burst request valid, held until the read master accepts it
// ST_DONE  | one-cycle done pulse, then back to idle
module axi_read_burst_splitter
   import axi_read_burst_splitter_pkg::*;
#(
   parameter int unsigned D_WIDTH   = 64,
   parameter int unsigned MAX_BEATS = AXI_MAX_BEATS,
   parameter int unsigned BOUNDARY  = AXI_BOUNDARY
) (
   input  logic                  sys_clock,
   input  logic                  async_reset,
   input  logic [AXI_ADDR_W-1:0] i_cmd_addr,
   input  logic [31:0]           i_cmd_bytes,
   input  logic                  i_cmd_valid,
   output logic                  o_cmd_ready,
   output logic [AXI_ADDR_W-1:0] or_bst_addr,
   output logic [AXI_LEN_W-1:0]  or_bst_len,
   output logic                  or_bst_valid,
   input  logic                  i_bst_ready,
   output logic                  or_done,
   output logic                  o_busy
);

   localparam int unsigned           BB         = D_WIDTH / 8;
   localparam int unsigned           BB_LOG     = clog2(BB);
   localparam logic [AXI_ADDR_W-1:0] ALIGN_MASK = ~AXI_ADDR_W'(BB - 1);

   state_e                state_q, state_d;
   logic [AXI_ADDR_W-1:0] addr_q, addr_d;
   logic [BEATS_W-1:0]    beats_rem_q, beats_rem_d;
   logic [AXI_ADDR_W-1:0] bst_addr_q, bst_addr_d;
   logic [AXI_LEN_W-1:0]  bst_len_q, bst_len_d;
   logic                  bst_valid_q, bst_valid_d;
   logic                  done_q, done_d;

   logic [N_W-1:0]        calc_n;
   logic [N_W-1:0]        issued_n;
   logic [BEATS_W-1:0]    beats_left;

   axi_burst_calc #(
      .BB        (BB),
      .MAX_BEATS (MAX_BEATS),
      .BOUNDARY  (BOUNDARY)
   ) u_calc (
      .addr      (addr_q),
      .beats_rem (beats_rem_q),
      .n         (calc_n)
   );

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      beats_rem_d = beats_rem_q;
      bst_addr_d  = bst_addr_q;
      bst_len_d   = bst_len_q;
      bst_valid_d = bst_valid_q;
      done_d      = 1'b0;
      // size of the burst currently on the bus, recovered from its len field
      issued_n    = N_W'(bst_len_q) + N_W'(1);
      beats_left  = beats_rem_q - BEATS_W'(issued_n);

      unique case (state_q)
         ST_IDLE: begin
            if (i_cmd_valid) begin
               addr_d      = i_cmd_addr & ALIGN_MASK;
               beats_rem_d = ({1'b0, i_cmd_bytes} + BEATS_W'(BB - 1)) >> BB_LOG;
               if (beats_rem_d == '0) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_CALC;
               end
            end
         end
         ST_CALC: begin
            bst_addr_d  = addr_q;
            bst_len_d   = AXI_LEN_W'(calc_n - N_W'(1));
            bst_valid_d = 1'b1;
            state_d     = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (i_bst_ready) begin
               addr_d      = addr_q + (AXI_ADDR_W'(issued_n) << BB_LOG);
               beats_rem_d = beats_left;
               bst_valid_d = 1'b0;
               if (beats_left == '0) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_CALC;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clock or posedge async_reset) begin
      if (async_reset) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         beats_rem_q <= '0;
         bst_addr_q  <= '0;
         bst_len_q   <= '0;
         bst_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         beats_rem_q <= beats_rem_d;
         bst_addr_q  <= bst_addr_d;
         bst_len_q   <= bst_len_d;
         bst_valid_q <= bst_valid_d;
         done_q      <= done_d;
      end
   end

   assign o_cmd_ready  = (state_q == ST_IDLE);
   assign o_busy       = (state_q != ST_IDLE);
   assign or_bst_addr  = bst_addr_q;
   assign or_bst_len   = bst_len_q;
   assign or_bst_valid = bst_valid_q;
   assign or_done      = done_q;

endmodule
